perceptron_layer: RTL and testbench

- Parametrised successor to the single perceptron: NUM_NEURONS neurons share one AXI-Stream input vector and compute in parallel.
- Each neuron owns an internal weight RAM and a bias register, both loaded through a simple config write port.
- Accumulation is saturating and fixed-point; the activation is selectable.
- Results leave as a serialized AXI-Stream, one beat per neuron with TID and TLAST. Sits between the input/previous-layer stream and the next layer or the DMA.

---
 rtl/perceptron_layer.sv | 114 +++++++++++
 tb/tb_perceptron_layer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/perceptron_layer.sv
// perceptron_layer: parallel fixed-point neurons over one input stream, serialized saturating activated outputs
module perceptron_layer #(
  parameter int DATA_W = 32,
  parameter int FRAC_BITS = 16,
  parameter int INPUT_SIZE = 784,
  parameter int NUM_NEURONS = 4,
  parameter ACTIVATION = "relu",
  parameter int ADDR_W = $clog2(INPUT_SIZE),
  parameter int SEL_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_areset,
  input  logic              cfg_wr_en,
  input  logic [SEL_W-1:0]  cfg_wr_sel,
  input  logic              cfg_wr_bias,
  input  logic [ADDR_W-1:0] cfg_wr_addr,
  input  logic [DATA_W-1:0] cfg_wr_data,
  output logic              cfg_busy,
  input  logic [DATA_W-1:0] x_tdata,
  input  logic              x_tvalid,
  output logic              x_tready,
  input  logic              x_tlast,
  output logic [DATA_W-1:0] a_tdata,
  output logic              a_tvalid,
  input  logic              a_tready,
  output logic              a_tlast,
  output logic [SEL_W-1:0]  a_tid,
  output logic              err_len
);
  localparam int AW = 2 * DATA_W;
  localparam int CW = ADDR_W + 1;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUTPUT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] count, idx;
  logic [1:0] dcnt;
  logic v1, v2, acc_in, last_beat, load_out, cfg_ok;
  logic signed [DATA_W-1:0] xq;
  logic [DATA_W-1:0] act [NUM_NEURONS];
  assign x_tready = state == IDLE || (state == ACCUM && count < CW'(INPUT_SIZE));
  assign cfg_busy = state != IDLE;
  assign acc_in = x_tvalid && x_tready;
  assign idx = state == IDLE ? '0 : count;
  assign last_beat = 32'(idx) == INPUT_SIZE - 1;
  assign load_out = state == DRAIN && dcnt == 2'd3;
  assign cfg_ok = cfg_wr_en && state == IDLE && !acc_in && 32'(cfg_wr_sel) < NUM_NEURONS
                  && (cfg_wr_bias || 32'(cfg_wr_addr) < INPUT_SIZE);
  always_comb begin
    state_nx = acc_in && last_beat ? DRAIN : acc_in ? ACCUM : load_out ? OUTPUT
             : (a_tvalid && a_tready && a_tlast) ? IDLE : state;
  end
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state <= IDLE;
      count <= '0;
      dcnt <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      err_len <= 1'b0;
    end else begin
      state <= state_nx;
      count <= state == OUTPUT ? '0 : acc_in ? idx + 1'b1 : count;
      dcnt <= state == DRAIN ? dcnt + 1'b1 : 2'd0;
      v1 <= acc_in;
      v2 <= v1;
      if (acc_in) xq <= x_tdata;
      if (acc_in && x_tlast != last_beat) err_len <= 1'b1;
    end
  end
  // drain counter gives a_tvalid exactly four edges after the last accepted beat
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      a_tvalid <= 1'b0;
      a_tlast <= 1'b0;
      a_tid <= '0;
      a_tdata <= '0;
    end else if (load_out) begin
      a_tvalid <= 1'b1;
      a_tlast <= NUM_NEURONS == 1;
      a_tid <= '0;
      a_tdata <= act[0];
    end else if (a_tvalid && a_tready) begin
      a_tvalid <= !a_tlast;
      a_tlast <= 32'(a_tid) + 2 == NUM_NEURONS;
      a_tid <= a_tid + 1'b1;
      a_tdata <= act[a_tid + 1'b1];
    end
  end
  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
    logic [DATA_W-1:0] wmem [INPUT_SIZE];
    logic [DATA_W-1:0] bias;
    logic signed [DATA_W-1:0] wq;
    logic signed [AW-1:0] pq, acc, sum, sh;
    logic [DATA_W-1:0] cl;
    logic ovf, hi, lo;
    always_ff @(posedge s_axi_aclk) begin
      if (cfg_ok && 32'(cfg_wr_sel) == n && !cfg_wr_bias) wmem[cfg_wr_addr] <= cfg_wr_data;
      if (cfg_ok && 32'(cfg_wr_sel) == n && cfg_wr_bias) bias <= cfg_wr_data;
      if (acc_in) wq <= wmem[idx[ADDR_W-1:0]];
      pq <= AW'(wq) * AW'(xq);
    end
    always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) acc <= '0;
      else if (state == IDLE && acc_in) acc <= {{DATA_W{bias[DATA_W-1]}}, bias} << FRAC_BITS;
      else if (v2) acc <= !ovf ? sum : acc[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end
    assign sum = acc + pq;
    assign ovf = acc[AW-1] == pq[AW-1] && sum[AW-1] != acc[AW-1];
    assign sh = acc >>> FRAC_BITS;
    assign hi = !sh[AW-1] && |sh[AW-2:DATA_W-1];
    assign lo = sh[AW-1] && !(&sh[AW-2:DATA_W-1]);
    assign cl = hi ? {1'b0, {(DATA_W-1){1'b1}}} : lo ? {1'b1, {(DATA_W-1){1'b0}}} : sh[DATA_W-1:0];
    assign act[n] = ACTIVATION == "relu" && cl[DATA_W-1] ? '0 : cl;
  end
endmodule

// File: tb/tb_perceptron_layer.sv
// tb_perceptron_layer: scoreboard bench driving relu and linear layer instances with shared stimulus
module tb_perceptron_layer;
  localparam logic [63:0] XV1 = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
  localparam logic [63:0] XS = {4{16'h7FFF}};
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic cfg_wr_en = 0, cfg_wr_sel = 0, cfg_wr_bias = 0;
  logic [1:0] cfg_wr_addr = 0;
  logic [15:0] cfg_wr_data = 0, x_tdata = 0;
  logic x_tvalid = 0, x_tlast = 0, a_tready = 1;
  logic r_busy, r_xrdy, r_tvalid, r_tlast, r_tid, r_err;
  logic n_busy, n_xrdy, n_tvalid, n_tlast, n_tid, n_err;
  logic [15:0] r_tdata, n_tdata;
  int compared = 0, mismatched = 0;
  logic [17:0] q_r[$], q_n[$];

  perceptron_layer #(.DATA_W(16), .FRAC_BITS(8), .INPUT_SIZE(4), .NUM_NEURONS(2), .ACTIVATION("relu")) u_relu (
    .s_axi_aclk(clk), .s_axi_areset(rst), .cfg_wr_en(cfg_wr_en), .cfg_wr_sel(cfg_wr_sel),
    .cfg_wr_bias(cfg_wr_bias), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data), .cfg_busy(r_busy),
    .x_tdata(x_tdata), .x_tvalid(x_tvalid), .x_tready(r_xrdy), .x_tlast(x_tlast),
    .a_tdata(r_tdata), .a_tvalid(r_tvalid), .a_tready(a_tready), .a_tlast(r_tlast), .a_tid(r_tid),
    .err_len(r_err));
  perceptron_layer #(.DATA_W(16), .FRAC_BITS(8), .INPUT_SIZE(4), .NUM_NEURONS(2), .ACTIVATION("none")) u_none (
    .s_axi_aclk(clk), .s_axi_areset(rst), .cfg_wr_en(cfg_wr_en), .cfg_wr_sel(cfg_wr_sel),
    .cfg_wr_bias(cfg_wr_bias), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data), .cfg_busy(n_busy),
    .x_tdata(x_tdata), .x_tvalid(x_tvalid), .x_tready(n_xrdy), .x_tlast(x_tlast),
    .a_tdata(n_tdata), .a_tvalid(n_tvalid), .a_tready(a_tready), .a_tlast(n_tlast), .a_tid(n_tid),
    .err_len(n_err));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // beats are packed as {tid, tlast, tdata}
  always @(negedge clk) begin
    if (!rst && r_tvalid && a_tready) begin
      if (q_r.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL relu_unexpected_beat: got %h, expected no beat", {r_tid, r_tlast, r_tdata});
      end else check("relu_beat", {r_tid, r_tlast, r_tdata}, q_r.pop_front());
    end
    if (!rst && n_tvalid && a_tready) begin
      if (q_n.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL none_unexpected_beat: got %h, expected no beat", {n_tid, n_tlast, n_tdata});
      end else check("none_beat", {n_tid, n_tlast, n_tdata}, q_n.pop_front());
    end
  end

  task automatic push(input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] n0, input logic [15:0] n1);
    q_r.push_back({2'b00, r0}); q_r.push_back({2'b11, r1});
    q_n.push_back({2'b00, n0}); q_n.push_back({2'b11, n1});
  endtask

  task automatic cfg(input logic sel, input logic b, input logic [1:0] addr, input logic [15:0] d);
    cfg_wr_en = 1; cfg_wr_sel = sel; cfg_wr_bias = b; cfg_wr_addr = addr; cfg_wr_data = d;
    @(posedge clk); #1;
    cfg_wr_en = 0;
  endtask

  task automatic load_weights(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] b0, input logic [15:0] b1);
    for (int i = 0; i < 4; i++) begin
      cfg(1'b0, 1'b0, 2'(i), w0);
      cfg(1'b1, 1'b0, 2'(i), w1);
    end
    cfg(1'b0, 1'b1, 2'd0, b0);
    cfg(1'b1, 1'b1, 2'd0, b1);
  endtask

  task automatic send_beat(input logic [15:0] d, input logic l);
    int t = 0;
    x_tdata = d; x_tlast = l; x_tvalid = 1;
    while (!r_xrdy && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("x_tready_wait", 32'(t < 50), 1);
    @(posedge clk); #1;
    x_tvalid = 0; x_tlast = 0;
  endtask

  task automatic send_frame(input logic [63:0] xv, input logic [3:0] tl);
    for (int i = 0; i < 4; i++) send_beat(xv[16*i +: 16], tl[i]);
  endtask

  task automatic wait_done();
    int t = 0;
    while ((q_r.size() != 0 || q_n.size() != 0) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("frame_done", 32'(t < 100), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("rst_tvalid", r_tvalid, 0);
    check("rst_tdata", r_tdata, 0);
    check("rst_tid", r_tid, 0);
    check("rst_tlast", r_tlast, 0);
    check("rst_err", r_err, 0);
    check("rst_xready", r_xrdy, 1);
    check("rst_busy", r_busy, 0);
    check("rst_none_tvalid", n_tvalid, 0);
    load_weights(16'h0100, 16'hFF00, 16'h0080, 16'h0000);
    push(16'h0A80, 16'h0000, 16'h0A80, 16'hF600);
    send_frame(XV1, 4'b1000);
    repeat (3) @(posedge clk);
    #1;
    check("tvalid_early", r_tvalid, 0);
    check("none_tvalid_early", n_tvalid, 0);
    check("busy_drain", r_busy, 1);
    check("xready_drain", r_xrdy, 0);
    @(posedge clk); #1;
    check("tvalid_latency", r_tvalid, 1);
    check("none_tvalid_latency", n_tvalid, 1);
    wait_done();
    check("xready_after", r_xrdy, 1);
    check("tvalid_after", r_tvalid, 0);
    check("err_clean", r_err, 0);
    a_tready = 0;
    push(16'h0A80, 16'h0000, 16'h0A80, 16'hF600);
    send_frame(XV1, 4'b1000);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("stall_tvalid", r_tvalid, 1);
      check("stall_tdata", r_tdata, 16'h0A80);
      check("stall_tid", r_tid, 0);
      check("stall_tlast", r_tlast, 0);
      check("stall_xready", r_xrdy, 0);
      check("stall_none_tdata", n_tdata, 16'h0A80);
      @(posedge clk); #1;
    end
    a_tready = 1;
    wait_done();
    check("xready_after_stall", r_xrdy, 1);
    push(16'h0A80, 16'h0000, 16'h0A80, 16'hF600);
    send_frame(XV1, 4'b1000);
    wait_done();
    send_beat(16'h0100, 0);
    send_beat(16'h0200, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("midrst_tvalid", r_tvalid, 0);
    check("midrst_xready", r_xrdy, 1);
    check("midrst_busy", r_busy, 0);
    check("midrst_none_xready", n_xrdy, 1);
    repeat (8) @(posedge clk);
    #1;
    check("midrst_no_output", r_tvalid, 0);
    push(16'h0A80, 16'h0000, 16'h0A80, 16'hF600);
    cfg_wr_en = 1; cfg_wr_sel = 0; cfg_wr_bias = 1; cfg_wr_addr = 0; cfg_wr_data = 16'h7F00;
    send_beat(16'h0100, 0);
    cfg_wr_en = 0;
    send_beat(16'h0200, 0);
    cfg(1'b0, 1'b1, 2'd0, 16'h7F00);
    send_beat(16'h0300, 0);
    send_beat(16'h0400, 1);
    wait_done();
    push(16'h0A80, 16'h0000, 16'h0A80, 16'hF600);
    send_frame(XV1, 4'b0010);
    wait_done();
    check("err_set", r_err, 1);
    check("none_err_set", n_err, 1);
    push(16'h0A80, 16'h0000, 16'h0A80, 16'hF600);
    send_frame(XV1, 4'b1000);
    wait_done();
    check("err_sticky", r_err, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("err_cleared", r_err, 0);
    load_weights(16'h7FFF, 16'h8000, 16'h0000, 16'h0000);
    push(16'h7FFF, 16'h0000, 16'h7FFF, 16'h8000);
    send_frame(XS, 4'b1000);
    wait_done();
    check("sat_err", r_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
